// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

  // Controller states; fixed 2-bit encodings.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Iteration counter width.
  // It is wide enough to hold SIZE itself, not just SIZE-1.
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Library ripple-carry adder: SIZE-bit operands, SIZE+1-bit sum (carry out in MSB).
module shift_add_multiplier_adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   sum
);

  logic c;

  // Bit-serial carry ripple, one full-adder cell per bit, LSB first.
  always_comb begin
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < SIZE; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    sum[SIZE] = c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier.
// Consumes one multiplier bit per clock and accumulates through the library adder.
// The product is 2*SIZE bits, is registered, and is held until the next completion.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int CW = cnt_width(SIZE);

  mul_state_t      state_q, state_d;
  logic [2*SIZE:0] acc_q;
  logic [2*SIZE:0] acc_shift;
  logic [SIZE-1:0] mcand_q;
  logic [SIZE-1:0] addend;
  logic [SIZE:0]   sum;
  logic [CW-1:0]   count_q;
  logic            last_iter;
  logic            accept;
  logic            unused_acc_msb;

  // Upper half of acc is the running partial product.
  // Lower half holds the multiplier bits not yet consumed.
  assign addend = acc_q[0] ? mcand_q : '0;

  shift_add_multiplier_adder #(.SIZE(SIZE)) u_adder (
    .a   (acc_q[2*SIZE-1:SIZE]),
    .b   (addend),
    .sum (sum)
  );

  // Logical right shift.
  // The adder carry lands in acc[2*SIZE-1], so nothing is lost for max operands.
  assign acc_shift = {sum, acc_q[SIZE-1:0]} >> 1;

  // The top bit of the shifted accumulator is always zero.
  // It exists only to keep the accumulator width uniform.
  assign unused_acc_msb = acc_q[2*SIZE] ^ acc_shift[2*SIZE];

  assign last_iter = (count_q == CW'(SIZE - 1));

  // A request is taken in IDLE and in DONE (back-to-back); RUN ignores start.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered status flags (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Datapath: operand capture, one shift-add step per RUN cycle, product load on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      count_q <= '0;
      product <= '0;
    end else if (accept) begin
      mcand_q <= multiplicand;
      acc_q   <= {{(SIZE+1){1'b0}}, multiplier};
      count_q <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_shift;
      count_q <= count_q + CW'(1);
      if (last_iter) product <= acc_shift[2*SIZE-1:0];
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at SIZE=4 and SIZE=8.
// The reference model is plain A*B plus the documented cycle timing.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_multiplier #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  // Present a request; returns 1 time unit after the accepting edge, start dropped.
  task automatic start_4(input logic [3:0] a, input logic [3:0] b);
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Called just after the accepting edge.
  // Checks 4 busy cycles with the old product held, then the done cycle with the new product.
  task automatic check_run_4(input logic [7:0] exp, input string name);
    logic [7:0] held;
    held = prod4;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      vectors++;
      if (busy4 !== 1'b1 || done4 !== 1'b0 || prod4 !== held) begin
        miscompares++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b product=%h, want busy=1 done=0 product=%h",
                 name, i, busy4, done4, prod4, held);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || prod4 !== exp) begin
      miscompares++;
      $display("FAIL %s done cycle: busy=%b done=%b product=%h, want busy=0 done=1 product=%h",
               name, busy4, done4, prod4, exp);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00 ||
        busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset state: busy4=%b done4=%b prod4=%h busy8=%b done8=%b prod8=%h, want all zero",
               busy4, done4, prod4, busy8, done8, prod8);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    start_4(4'd5, 4'd3);
    check_run_4(8'h0F, "5x3");
    // Product must hold once the controller returns to idle.
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || prod4 !== 8'h0F) begin
        miscompares++;
        $display("FAIL hold 5x3: busy=%b done=%b product=%h, want busy=0 done=0 product=0f",
                 busy4, done4, prod4);
      end
    end
    start_4(4'd15, 4'd15);
    check_run_4(8'hE1, "15x15");
    @(posedge clk); #1;
  endtask

  task automatic test_zero_operands;
    start_4(4'd0, 4'd9);
    check_run_4(8'h00, "0x9");
    @(posedge clk); #1;
    start_4(4'd9, 4'd0);
    check_run_4(8'h00, "9x0");
    @(posedge clk); #1;
  endtask

  // A request raised mid-run must be ignored.
  // A request raised in the done cycle starts the next run immediately.
  task automatic test_back_to_back;
    start_4(4'd7, 4'd6);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      start4 = (i == 1);
      if (i == 1) begin a4 = 4'd2; b4 = 4'd2; end
      vectors++;
      if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore-start cycle %0d: busy=%b done=%b, want busy=1 done=0", i, busy4, done4);
      end
    end
    start4 = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (done4 !== 1'b1 || prod4 !== 8'd42) begin
      miscompares++;
      $display("FAIL 7x6 with ignored start: done=%b product=%0d, want done=1 product=42", done4, prod4);
    end
    start_4(4'd3, 4'd3);
    check_run_4(8'd9, "back-to-back 3x3");
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-run clears everything at once; the block is usable afterwards.
  task automatic test_reset_midrun;
    start_4(4'd12, 4'd11);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
      miscompares++;
      $display("FAIL async reset mid-run: busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start_4(4'd2, 4'd3);
    check_run_4(8'd6, "2x3 after reset");
    @(posedge clk); #1;
  endtask

  task automatic test_random_4;
    logic [3:0] a, b;
    for (int n = 0; n < 100; n++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      start_4(a, b);
      check_run_4(8'(a) * 8'(b), "random size4");
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  // One SIZE=8 multiply.
  // The wait for done is bounded; the count of busy cycles must be exactly 8.
  task automatic mul_8(input logic [7:0] a, input logic [7:0] b, input string name);
    int n, nbusy;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0; nbusy = 0;
    while (done8 !== 1'b1 && n < 20) begin
      if (busy8 === 1'b1) nbusy++;
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (done8 !== 1'b1 || nbusy != 8 || prod8 !== exp) begin
      miscompares++;
      $display("FAIL %s %0dx%0d: done=%b busy_cycles=%0d product=%h, want done=1 busy_cycles=8 product=%h",
               name, a, b, done8, nbusy, prod8, exp);
    end
  endtask

  task automatic test_size8;
    mul_8(8'd255, 8'd255, "size8 max");
    for (int n = 0; n < 1000; n++) mul_8(8'($urandom), 8'($urandom), "size8 random");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_operands;
    test_back_to_back;
    test_reset_midrun;
    test_random_4;
    test_size8;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
